alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational alu (primary/secondary operand, 4-bit cmnd, 16-bit result, 3-bit flags)
//  between N_REQ requesters (decode units, address generators, test port).
//  Accepts one request per transaction through a valid/ready handshake and drives the alu operand and command inputs.
//  Captures the alu result and flags, then returns them to the winning requester through a response handshake.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  IDX_W    2   grant index width, clog2(N_REQ)
// PORTS
//  clk                    in   1         rising-edge clock
//  reset                  in   1         asynchronous, active-high
//  req_valid              in   N_REQ     request pending, one bit per requester
//  req_ready              out  N_REQ     one-hot accept strobe
//  req_cmnd               in   4*N_REQ   `ALU_* command code, slice i belongs to requester i
//  req_primary            in   8*N_REQ   primary operand slices
//  req_secondary          in   8*N_REQ   secondary operand slices
//  rsp_valid              out  N_REQ     one-hot result-available signal
//  rsp_ready              in   N_REQ     requester consumes its result
//  rsp_result             out  16        captured alu result (shared by all requesters)
//  rsp_flags              out  3         captured alu flags, passed through unchanged
//  alu_primary_operand    out  8         to alu
//  alu_secondary_operand  out  8         to alu
//  alu_cmnd               out  4         to alu
//  alu_result             in   16        from alu
//  alu_flags              in   3         from alu
//  busy                   out  1         high in any state except IDLE
// BEHAVIOUR
//  States: IDLE -> EXEC -> RESP -> IDLE. Encoding: IDLE=0, EXEC=1, RESP=2.
//  Reset (async, any state):
//   - state=IDLE, rr_ptr=0.
//   - All outputs 0: alu_* , rsp_result, rsp_flags, req_ready, rsp_valid, busy.
//   - Any in-flight transaction is dropped with no response.
//  IDLE, when any req_valid is set:
//   - Arbiter picks winner w.
//   - req_ready[w]=1 for exactly that cycle (combinational from req_valid and rr_ptr).
//   - Registers req_cmnd/primary/secondary slice w into the alu_* outputs and stores grant index w.
//   - Next state EXEC.
//  IDLE, no request: outputs hold their last values and req_ready=0.
//  EXEC: rsp_result<=alu_result and rsp_flags<=alu_flags at the clock edge; next state RESP.
//  RESP:
//   - rsp_valid[w]=1.
//   - When rsp_ready[w]=1: rr_ptr<=(w+1) mod N_REQ, next state IDLE.
//   - Otherwise hold indefinitely with result and flags stable.
//   - rsp_ready on any bit other than w is ignored.
//  Timing: accept at edge T, rsp_valid high from T+2. Best-case throughput is one op per 3 cycles.
//  Round-robin: search starts at rr_ptr with wraparound. Index N_REQ-1 is followed by index 0.
//  A requester must keep req_valid and its operands stable until req_ready.
//   - Dropping req_valid before req_ready withdraws the request with no effect.
//  Unknown cmnd codes are forwarded unchanged; the alu defines the result.
//  A requester may re-raise req_valid while in RESP. It is not accepted before the return to IDLE.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority, lowest index wins.
//   - rr_ptr is removed and the pointer update has no effect.
//  Not defined: round-robin as described above (default).
// STRUCTURE
//  constants.v (shared include) gains:
//   - ALU_CMND_W=4, ALU_OPND_W=8, ALU_RES_W=16, ALU_FLAG_W=3.
//   - ALU_ARB_IDLE/EXEC/RESP state codes.
//  `ALU_* command codes stay in constants.v.
//  Sub-module rr_arbiter (N_REQ, IDX_W): req vector + ptr -> one-hot grant + index, purely combinational.
//  alu_arbiter holds the FSM, the grant register and the capture registers.
//  The alu is instantiated beside this block at top level, not inside it.
// TESTING
//  1. Reset asserted mid-EXEC -> all outputs 0 immediately (async), state IDLE, no rsp_valid afterwards.
//  2. Requester 0: `ALU_ADD, 10, 5 -> req_ready[0] at T; rsp_valid[0] at T+2 with rsp_result[7:0]=15, zero flag clear.
//  3. Requester 2: `ALU_MULTIPLY, 4, 5 -> rsp_result=16'd20.
//     Hold rsp_ready[2]=0 for 5 cycles -> result stable, busy=1, no new accept.
//  4. All 4 requesters valid continuously with `ALU_SUBTRACT 10,3 -> grant order 0,1,2,3,0.
//     Every result is 7. With ALU_ARB_FIXED_PRIO_EN, grants are 0,0,0...
//  5. Requester 1: `ALU_TWOS_COMPLEMENT, 1 -> rsp_result[7:0]=8'hFF, negative flag set.
//     rsp_ready on bit 3 while waiting is ignored.
//  6. Requester 3 drops req_valid during RESP of requester 1 (`ALU_AND F0,0F -> 00, zero flag set)
//     -> requester 3 is never granted and no stray req_ready appears.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, state codes, alu command codes and flag bit positions
// for the alu arbiter slice.
package alu_arbiter_pkg;

  localparam int ALU_CMND_W = 4;
  localparam int ALU_OPND_W = 8;
  localparam int ALU_RES_W  = 16;
  localparam int ALU_FLAG_W = 3;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE = 2'd0,
    ALU_ARB_EXEC = 2'd1,
    ALU_ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic [ALU_CMND_W-1:0] ALU_ADD             = 4'h0;
  localparam logic [ALU_CMND_W-1:0] ALU_SUBTRACT        = 4'h1;
  localparam logic [ALU_CMND_W-1:0] ALU_MULTIPLY        = 4'h2;
  localparam logic [ALU_CMND_W-1:0] ALU_AND             = 4'h3;
  localparam logic [ALU_CMND_W-1:0] ALU_OR              = 4'h4;
  localparam logic [ALU_CMND_W-1:0] ALU_XOR             = 4'h5;
  localparam logic [ALU_CMND_W-1:0] ALU_TWOS_COMPLEMENT = 4'h6;

  localparam int ALU_FLAG_ZERO  = 0;
  localparam int ALU_FLAG_NEG   = 1;
  localparam int ALU_FLAG_CARRY = 2;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts at ptr and wraps.
// Ports: req (pending vector), ptr (start index) -> grant (one-hot), idx (winner).
import alu_arbiter_pkg::*;

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external alu among N_REQ requesters.
// Ports: clk, reset (async high); req_valid/ready/cmnd/primary/secondary
// from requesters; rsp_valid/ready/result/flags back to them;
// alu_primary_operand/secondary_operand/cmnd to alu, alu_result/flags
// from alu; busy. Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [ALU_CMND_W*N_REQ-1:0] req_cmnd,
  input  logic [ALU_OPND_W*N_REQ-1:0] req_primary,
  input  logic [ALU_OPND_W*N_REQ-1:0] req_secondary,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [ALU_RES_W-1:0]        rsp_result,
  output logic [ALU_FLAG_W-1:0]       rsp_flags,
  output logic [ALU_OPND_W-1:0]       alu_primary_operand,
  output logic [ALU_OPND_W-1:0]       alu_secondary_operand,
  output logic [ALU_CMND_W-1:0]       alu_cmnd,
  input  logic [ALU_RES_W-1:0]        alu_result,
  input  logic [ALU_FLAG_W-1:0]       alu_flags,
  output logic                        busy
);

  arb_state_t       state;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] ptr;
  logic             done;

  assign done = (state == ALU_ARB_RESP) && rsp_ready[gnt_idx];

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  assign ptr = rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (done) begin
      rr_ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ?
                '0 : gnt_idx + IDX_W'(1);
    end
  end
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win),
    .idx   (win_idx)
  );

  // Accept strobe is combinational so the requester sees it in the
  // same cycle its operands are registered.
  assign req_ready = (state == ALU_ARB_IDLE && !reset) ? win : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ALU_ARB_IDLE;
      gnt_idx               <= '0;
      alu_cmnd              <= '0;
      alu_primary_operand   <= '0;
      alu_secondary_operand <= '0;
      rsp_result            <= '0;
      rsp_flags             <= '0;
      rsp_valid             <= '0;
      busy                  <= 1'b0;
    end else begin
      unique case (state)
        ALU_ARB_IDLE: begin
          if (|req_valid) begin
            alu_cmnd <= req_cmnd[win_idx*ALU_CMND_W +: ALU_CMND_W];
            alu_primary_operand <=
              req_primary[win_idx*ALU_OPND_W +: ALU_OPND_W];
            alu_secondary_operand <=
              req_secondary[win_idx*ALU_OPND_W +: ALU_OPND_W];
            gnt_idx <= win_idx;
            busy    <= 1'b1;
            state   <= ALU_ARB_EXEC;
          end
        end
        ALU_ARB_EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_valid  <= N_REQ'(1) << gnt_idx;
          state      <= ALU_ARB_RESP;
        end
        ALU_ARB_RESP: begin
          if (done) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= ALU_ARB_IDLE;
          end
        end
        default: state <= ALU_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural alu beside it
// and a scoreboard of expected responses filled at each accept.
import alu_arbiter_pkg::*;

module tb_alu_arbiter;

  localparam int N = 4;
  localparam int IW = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_cmnd;
  logic [8*N-1:0]  req_primary;
  logic [8*N-1:0]  req_secondary;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [15:0]     rsp_result;
  logic [2:0]      rsp_flags;
  logic [7:0]      alu_p;
  logic [7:0]      alu_s;
  logic [3:0]      alu_c;
  logic [15:0]     alu_r;
  logic [2:0]      alu_f;
  logic            busy;

  alu_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_cmnd              (req_cmnd),
    .req_primary           (req_primary),
    .req_secondary         (req_secondary),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_result            (rsp_result),
    .rsp_flags             (rsp_flags),
    .alu_primary_operand   (alu_p),
    .alu_secondary_operand (alu_s),
    .alu_cmnd              (alu_c),
    .alu_result            (alu_r),
    .alu_flags             (alu_f),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural alu
  logic [8:0] sum9;
  always_comb begin
    sum9  = {1'b0, alu_p} + {1'b0, alu_s};
    alu_r = '0;
    case (alu_c)
      ALU_ADD:             alu_r = {7'b0, sum9};
      ALU_SUBTRACT:        alu_r = {8'b0, alu_p - alu_s};
      ALU_MULTIPLY:        alu_r = alu_p * alu_s;
      ALU_AND:             alu_r = {8'b0, alu_p & alu_s};
      ALU_OR:              alu_r = {8'b0, alu_p | alu_s};
      ALU_XOR:             alu_r = {8'b0, alu_p ^ alu_s};
      ALU_TWOS_COMPLEMENT: alu_r = {8'b0, 8'(-alu_p)};
      default:             alu_r = '0;
    endcase
    alu_f = '0;
    alu_f[ALU_FLAG_ZERO]  = (alu_r == 16'd0);
    alu_f[ALU_FLAG_NEG]   = alu_r[7];
    alu_f[ALU_FLAG_CARRY] = (alu_c == ALU_ADD) && alu_r[8];
  end

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t        exp_q[$];
  int          gnt_q[$];
  logic [15:0] exp_res [N];
  logic [2:0]  exp_flg [N];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_cnt = 0;
  bit          prev_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: push on accept, pop and compare on response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0) begin
        chk("rdy_1hot", $countones(req_ready), 1);
        chk("rdy_valid", req_ready & ~req_valid, 0);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            exp_q.push_back('{i, exp_res[i], exp_flg[i]});
            gnt_q.push_back(i);
            acc_cyc = cyc;
            acc_cnt++;
          end
        end
      end
      if (rsp_valid != '0 && !prev_v)
        chk("latency", cyc - acc_cyc, 2);
      prev_v = (rsp_valid != '0);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_idx", rsp_valid, 1 << e.idx);
          chk("rsp_res", rsp_result, e.res);
          chk("rsp_flg", rsp_flags, e.flg);
        end
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic set_req(input int i, input logic [3:0] c,
                         input logic [7:0] p, input logic [7:0] s,
                         input logic [15:0] r, input logic [2:0] f);
    req_cmnd[i*4 +: 4]      = c;
    req_primary[i*8 +: 8]   = p;
    req_secondary[i*8 +: 8] = s;
    exp_res[i] = r;
    exp_flg[i] = f;
  endtask

  // returns #1 after the edge on which accept number n happened
  task automatic wait_acc(input int n);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      if (acc_cnt >= n) break;
    end
    #1;
    if (k == 40) chk("acc_timeout", acc_cnt, n);
  endtask

  task automatic wait_rsp(input int i);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[i]) break;
    end
    if (k == 40) chk("rsp_timeout", rsp_valid, 1 << i);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && rsp_valid == '0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu"}, {alu_p, alu_s, alu_c}, 0);
    chk({tag, "_rsp"}, {rsp_result, rsp_flags}, 0);
    chk({tag, "_hs"}, {req_ready, rsp_valid, busy}, 0);
  endtask

  int n0;
  int base;
  logic [N-1:0] seen;
  int order [5];

  initial begin
    reset         = 1'b1;
    req_valid     = '0;
    rsp_ready     = '1;
    req_cmnd      = '0;
    req_primary   = '0;
    req_secondary = '0;
    for (int i = 0; i < N; i++) begin
      exp_res[i] = '0;
      exp_flg[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 chk_zero("rst0");
    reset = 1'b0;

    // add on requester 0
    set_req(0, ALU_ADD, 8'd10, 8'd5, 16'd15, 3'b000);
    n0 = acc_cnt;
    req_valid[0] = 1'b1;
    wait_acc(n0 + 1);
    req_valid[0] = 1'b0;
    drain();

    // multiply on requester 2 with delayed consume
    set_req(2, ALU_MULTIPLY, 8'd4, 8'd5, 16'd20, 3'b000);
    set_req(1, ALU_ADD, 8'd1, 8'd2, 16'd3, 3'b000);
    rsp_ready = '0;
    n0 = acc_cnt;
    req_valid[2] = 1'b1;
    wait_acc(n0 + 1);
    req_valid[2] = 1'b0;
    req_valid[1] = 1'b1;
    wait_rsp(2);
    for (int k = 0; k < 5; k++) begin
      chk("hold_res", rsp_result, 16'd20);
      chk("hold_busy", busy, 1);
      chk("hold_rdy", req_ready, 0);
      chk("hold_vld", rsp_valid, 4'b0100);
      @(posedge clk); #1;
    end
    rsp_ready = '1;
    wait_acc(n0 + 2);
    req_valid[1] = 1'b0;
    drain();

    // reset in the middle of EXEC drops the transaction
    set_req(0, ALU_ADD, 8'd3, 8'd4, 16'd7, 3'b000);
    n0 = acc_cnt;
    req_valid[0] = 1'b1;
    wait_acc(n0 + 1);
    req_valid[0] = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero("rst_exec");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    chk("rst_norsp", seen, 0);

    // all requesters continuously valid
    for (int i = 0; i < N; i++)
      set_req(i, ALU_SUBTRACT, 8'd10, 8'd3, 16'd7, 3'b000);
    base = gnt_q.size();
    n0 = acc_cnt;
    req_valid = '1;
    wait_acc(n0 + 5);
    req_valid = '0;
    drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++) begin
      if (gnt_q.size() > base + k)
        chk("rr_order", gnt_q[base + k], order[k]);
      else
        chk("rr_count", gnt_q.size(), base + 5);
    end

    // twos complement, stray rsp_ready on bit 3 ignored
    set_req(1, ALU_TWOS_COMPLEMENT, 8'd1, 8'd0, 16'h00FF, 3'b010);
    rsp_ready = 4'b1000;
    n0 = acc_cnt;
    req_valid[1] = 1'b1;
    wait_acc(n0 + 1);
    req_valid[1] = 1'b0;
    wait_rsp(1);
    for (int k = 0; k < 4; k++) begin
      chk("stray_vld", rsp_valid, 4'b0010);
      chk("stray_res", rsp_result, 16'h00FF);
      @(posedge clk); #1;
    end
    rsp_ready = 4'b0010;
    drain();

    // requester 3 withdraws while requester 1 is in RESP
    set_req(1, ALU_AND, 8'hF0, 8'h0F, 16'h0000, 3'b001);
    set_req(3, ALU_ADD, 8'd1, 8'd1, 16'd2, 3'b000);
    rsp_ready = '0;
    n0 = acc_cnt;
    req_valid[1] = 1'b1;
    wait_acc(n0 + 1);
    req_valid[1] = 1'b0;
    wait_rsp(1);
    req_valid[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("wd_rdy", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid[3] = 1'b0;
    rsp_ready = '1;
    drain();
    repeat (4) @(posedge clk);
    #1 chk("wd_no_gnt", acc_cnt, n0 + 1);
    chk("idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
